// File: rtl/pab_arb_pkg.sv
// Shared definitions for the PAB round-robin arbiter.
//   state_t      : arbiter sequencing states
//   TIMEOUT_DATA : read data returned to a core when a transaction times out
package pab_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/pab_rr_pick.sv
// Combinational round-robin picker.
// Scans req starting at index ptr, wrapping at NCORES, and returns the first
// requesting index.
//   req : per-core request vector
//   ptr : index holding highest priority this round
//   sel : chosen index (0 when nothing requests)
//   any : at least one request present
module pab_rr_pick
    import pab_arb_pkg::*;
#(
    parameter int NCORES = 2,
    parameter int IW     = $clog2(NCORES)
) (
    input  logic [NCORES-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [IW-1:0]     sel,
    output logic              any
);

    localparam logic [IW:0] NC = (IW+1)'(NCORES);

    logic [IW:0] idx;

    // Walk from the farthest candidate back towards ptr so the candidate
    // closest to ptr is the last one written and therefore wins.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = '0;
        for (int k = NCORES-1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= NC) begin
                idx = idx - NC;
            end
            if (req[idx[IW-1:0]]) begin
                sel = idx[IW-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pab_rr_arbiter.sv
// Round-robin arbiter sharing one PAB memory port between NCORES cores.
// One core is granted per transaction in rotating priority; every other
// requester is stalled through HLT until its own transaction completes.
//
// Ports
//   CLK, RESN            clock (posedge) and asynchronous active-low reset
//   DADDR/DATAO/BE       per-core address, write data, byte enables (core i at slice i)
//   WR/RD                per-core write / read request
//   DATAI                read data shared by all cores, valid when own HLT drops
//   HLT                  per-core stall (combinational: REQ & ~REL)
//   GNT                  one-hot index of the core being served, 0 when idle
//   ERR                  sticky timeout flag
//   PAB_*                request towards the memory controller
//   MEM_READY/MEM_VALID  controller accept / transaction done
//   MEM_DATA             read data from the controller
//
// Build option
//   PAB_TIMEOUT_EN : when defined, a transaction that sees no MEM_VALID within
//                    TIMEOUT cycles of its grant is force-completed with
//                    TIMEOUT_DATA and ERR is set. When undefined the arbiter
//                    waits indefinitely and ERR is tied low.
module pab_rr_arbiter
    import pab_arb_pkg::*;
#(
    parameter int NCORES  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   CLK,
    input  logic                   RESN,
    input  logic [32*NCORES-1:0]   DADDR,
    input  logic [32*NCORES-1:0]   DATAO,
    input  logic [NCORES-1:0]      WR,
    input  logic [NCORES-1:0]      RD,
    input  logic [4*NCORES-1:0]    BE,
    output logic [31:0]            DATAI,
    output logic [NCORES-1:0]      HLT,
    output logic [NCORES-1:0]      GNT,
    output logic                   ERR,
    output logic [31:0]            PAB_ADDR,
    output logic [31:0]            PAB_DATA,
    output logic [3:0]             PAB_BE,
    output logic                   PAB_RD,
    output logic                   PAB_WR,
    output logic                   PAB_VALID,
    input  logic                   MEM_READY,
    input  logic                   MEM_VALID,
    input  logic [31:0]            MEM_DATA
);

    localparam int          IW   = $clog2(NCORES);
    localparam logic [IW-1:0] LAST = IW'(NCORES-1);

    if (NCORES < 2 || TIMEOUT < 1) begin : g_param_check
        $error("pab_rr_arbiter: NCORES must be >= 2 and TIMEOUT >= 1");
    end

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      sel_q;
    logic [NCORES-1:0]  rel;
    logic [NCORES-1:0]  req;

    logic [IW-1:0]      pick_sel;
    logic               pick_any;

    logic [31:0]        w_addr;
    logic [31:0]        w_data;
    logic [3:0]         w_be;
    logic               w_wr;
    logic               w_rd;

    logic               mem_done;
    logic               tmo_hit;

    assign req = WR | RD;
    // A fresh request stalls in the same cycle; only the REL pulse of a
    // completed transaction lets a core run on.
    assign HLT = req & ~rel;

    pab_rr_pick #(
        .NCORES (NCORES),
        .IW     (IW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .sel (pick_sel),
        .any (pick_any)
    );

    // Winner's request fields.
    always_comb begin
        w_addr = '0;
        w_data = '0;
        w_be   = '0;
        w_wr   = 1'b0;
        w_rd   = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            if (pick_sel == IW'(i)) begin
                w_addr = DADDR[32*i +: 32];
                w_data = DATAO[32*i +: 32];
                w_be   = BE[4*i +: 4];
                w_wr   = WR[i];
                w_rd   = RD[i];
            end
        end
    end

    // MEM_VALID only counts while a transaction is outstanding; in ISSUE it
    // must coincide with acceptance.
    assign mem_done = ((state == ISSUE) && MEM_READY && MEM_VALID) ||
                      ((state == WAIT)  && MEM_VALID);

`ifdef PAB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT+1);

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = ((state == ISSUE) || (state == WAIT)) && !mem_done &&
                     (tmo_cnt == TMO_W'(TIMEOUT-1));

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            tmo_cnt <= '0;
            ERR     <= 1'b0;
        end else begin
            if ((state == IDLE) && pick_any) begin
                tmo_cnt <= '0;
            end else if ((state == ISSUE) || (state == WAIT)) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (tmo_hit) begin
                ERR <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign ERR     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            state     <= IDLE;
            ptr       <= '0;
            sel_q     <= '0;
            rel       <= '0;
            GNT       <= '0;
            DATAI     <= '0;
            PAB_ADDR  <= '0;
            PAB_DATA  <= '0;
            PAB_BE    <= '0;
            PAB_RD    <= 1'b0;
            PAB_WR    <= 1'b0;
            PAB_VALID <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        sel_q     <= pick_sel;
                        PAB_ADDR  <= w_addr;
                        PAB_DATA  <= w_data;
                        PAB_BE    <= w_be;
                        // Write wins when a core raises both strobes.
                        PAB_WR    <= w_wr;
                        PAB_RD    <= w_rd & ~w_wr;
                        PAB_VALID <= 1'b1;
                        GNT       <= NCORES'(1) << pick_sel;
                        ptr       <= (pick_sel == LAST) ? '0 : pick_sel + IW'(1);
                        state     <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (mem_done || tmo_hit) begin
                        if (PAB_RD) begin
                            DATAI <= tmo_hit ? TIMEOUT_DATA : MEM_DATA;
                        end
                        rel       <= NCORES'(1) << sel_q;
                        PAB_RD    <= 1'b0;
                        PAB_WR    <= 1'b0;
                        PAB_VALID <= 1'b0;
                        state     <= RELEASE;
                    end else if ((state == ISSUE) && MEM_READY) begin
                        PAB_VALID <= 1'b0;
                        state     <= WAIT;
                    end
                end
                RELEASE: begin
                    // One bubble: a core that just dropped its request cannot
                    // be picked again off a stale REQ.
                    rel   <= '0;
                    GNT   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pab_rr_arbiter.sv
module tb_pab_rr_arbiter;

    logic        CLK = 1'b0;
    logic        RESN;
    logic [63:0] DADDR;
    logic [63:0] DATAO;
    logic [1:0]  WR;
    logic [1:0]  RD;
    logic [7:0]  BE;
    logic [31:0] DATAI;
    logic [1:0]  HLT;
    logic [1:0]  GNT;
    logic        ERR;
    logic [31:0] PAB_ADDR;
    logic [31:0] PAB_DATA;
    logic [3:0]  PAB_BE;
    logic        PAB_RD;
    logic        PAB_WR;
    logic        PAB_VALID;
    logic        MEM_READY;
    logic        MEM_VALID;
    logic [31:0] MEM_DATA;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pab_rr_arbiter #(
        .NCORES  (2),
        .TIMEOUT (8)
    ) dut (
        .CLK       (CLK),
        .RESN      (RESN),
        .DADDR     (DADDR),
        .DATAO     (DATAO),
        .WR        (WR),
        .RD        (RD),
        .BE        (BE),
        .DATAI     (DATAI),
        .HLT       (HLT),
        .GNT       (GNT),
        .ERR       (ERR),
        .PAB_ADDR  (PAB_ADDR),
        .PAB_DATA  (PAB_DATA),
        .PAB_BE    (PAB_BE),
        .PAB_RD    (PAB_RD),
        .PAB_WR    (PAB_WR),
        .PAB_VALID (PAB_VALID),
        .MEM_READY (MEM_READY),
        .MEM_VALID (MEM_VALID),
        .MEM_DATA  (MEM_DATA)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        WR        = 2'b00;
        RD        = 2'b00;
        MEM_READY = 1'b0;
        MEM_VALID = 1'b0;
    endtask

    task automatic test_reset;
        RESN     = 1'b0;
        DADDR    = '0;
        DATAO    = '0;
        BE       = '0;
        MEM_DATA = '0;
        idle_inputs();
        tick();
        tick();
        checks++; if (PAB_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", PAB_VALID); end
        checks++; if ({PAB_RD, PAB_WR} !== 2'b00) begin failures++; $display("FAIL reset_rdwr got=%b exp=00", {PAB_RD, PAB_WR}); end
        checks++; if (PAB_ADDR !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", PAB_ADDR); end
        checks++; if (GNT !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", GNT); end
        checks++; if (DATAI !== 32'h0) begin failures++; $display("FAIL reset_datai got=%h exp=0", DATAI); end
        checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", ERR); end
        checks++; if (HLT !== 2'b00) begin failures++; $display("FAIL reset_hlt got=%b exp=00", HLT); end
        RESN = 1'b1;
        tick();
    endtask

    task automatic test_single;
        DADDR[31:0] = 32'h0000_0100;
        RD          = 2'b01;
        #1;
        checks++; if (HLT !== 2'b01) begin failures++; $display("FAIL single_hlt_c0 got=%b exp=01", HLT); end
        tick();
        checks++; if (PAB_VALID !== 1'b1) begin failures++; $display("FAIL single_valid_c1 got=%b exp=1", PAB_VALID); end
        checks++; if ({PAB_RD, PAB_WR} !== 2'b10) begin failures++; $display("FAIL single_rdwr_c1 got=%b exp=10", {PAB_RD, PAB_WR}); end
        checks++; if (PAB_ADDR !== 32'h0000_0100) begin failures++; $display("FAIL single_addr_c1 got=%h exp=00000100", PAB_ADDR); end
        checks++; if (GNT !== 2'b01) begin failures++; $display("FAIL single_gnt_c1 got=%b exp=01", GNT); end
        checks++; if (HLT !== 2'b01) begin failures++; $display("FAIL single_hlt_c1 got=%b exp=01", HLT); end
        MEM_READY = 1'b1;
        MEM_VALID = 1'b1;
        MEM_DATA  = 32'hCAFE_0001;
        tick();
        checks++; if (HLT !== 2'b00) begin failures++; $display("FAIL single_hlt_c2 got=%b exp=00", HLT); end
        checks++; if (DATAI !== 32'hCAFE_0001) begin failures++; $display("FAIL single_datai_c2 got=%h exp=cafe0001", DATAI); end
        checks++; if (PAB_VALID !== 1'b0) begin failures++; $display("FAIL single_valid_c2 got=%b exp=0", PAB_VALID); end
        idle_inputs();
        tick();
        checks++; if (GNT !== 2'b00) begin failures++; $display("FAIL single_gnt_c3 got=%b exp=00", GNT); end
    endtask

    task automatic test_write;
        DADDR[63:32] = 32'h0000_0200;
        DATAO[63:32] = 32'h1234_5678;
        BE[7:4]      = 4'b0011;
        WR           = 2'b10;
        tick();
        checks++; if ({PAB_RD, PAB_WR} !== 2'b01) begin failures++; $display("FAIL write_rdwr got=%b exp=01", {PAB_RD, PAB_WR}); end
        checks++; if (PAB_DATA !== 32'h1234_5678) begin failures++; $display("FAIL write_data got=%h exp=12345678", PAB_DATA); end
        checks++; if (PAB_BE !== 4'b0011) begin failures++; $display("FAIL write_be got=%b exp=0011", PAB_BE); end
        checks++; if (PAB_ADDR !== 32'h0000_0200) begin failures++; $display("FAIL write_addr got=%h exp=00000200", PAB_ADDR); end
        checks++; if (GNT !== 2'b10) begin failures++; $display("FAIL write_gnt got=%b exp=10", GNT); end
        MEM_READY = 1'b1;
        MEM_VALID = 1'b1;
        MEM_DATA  = 32'hDEAD_BEEF;
        tick();
        checks++; if (HLT !== 2'b00) begin failures++; $display("FAIL write_hlt got=%b exp=00", HLT); end
        checks++; if (DATAI !== 32'hCAFE_0001) begin failures++; $display("FAIL write_datai got=%h exp=cafe0001", DATAI); end
        idle_inputs();
        tick();
        // Both strobes from one core: the write takes precedence.
        WR = 2'b10;
        RD = 2'b10;
        tick();
        checks++; if ({PAB_RD, PAB_WR} !== 2'b01) begin failures++; $display("FAIL wrrd_rdwr got=%b exp=01", {PAB_RD, PAB_WR}); end
        MEM_READY = 1'b1;
        MEM_VALID = 1'b1;
        MEM_DATA  = 32'hBAD0_BAD0;
        tick();
        checks++; if (DATAI !== 32'hCAFE_0001) begin failures++; $display("FAIL wrrd_datai got=%h exp=cafe0001", DATAI); end
        idle_inputs();
        tick();
    endtask

    task automatic test_contention;
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_hlt;
        logic [31:0] exp_data;
        RD        = 2'b11;
        MEM_READY = 1'b1;
        MEM_VALID = 1'b1;
        for (int n = 0; n < 4; n++) begin
            exp_gnt  = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_hlt  = ~exp_gnt;
            exp_data = 32'hA000_0000 + 32'(n);
            tick();
            checks++; if (GNT !== exp_gnt) begin failures++; $display("FAIL cont_gnt n=%0d got=%b exp=%b", n, GNT, exp_gnt); end
            MEM_DATA = exp_data;
            tick();
            checks++; if (HLT !== exp_hlt) begin failures++; $display("FAIL cont_hlt n=%0d got=%b exp=%b", n, HLT, exp_hlt); end
            checks++; if (DATAI !== exp_data) begin failures++; $display("FAIL cont_datai n=%0d got=%h exp=%h", n, DATAI, exp_data); end
            tick();
            checks++; if (GNT !== 2'b00) begin failures++; $display("FAIL cont_bubble n=%0d got=%b exp=00", n, GNT); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_split;
        DADDR[31:0] = 32'h0000_0300;
        RD          = 2'b01;
        tick();
        checks++; if (PAB_VALID !== 1'b1) begin failures++; $display("FAIL split_valid_c1 got=%b exp=1", PAB_VALID); end
        MEM_READY = 1'b1;
        tick();
        checks++; if (PAB_VALID !== 1'b0) begin failures++; $display("FAIL split_valid_c2 got=%b exp=0", PAB_VALID); end
        checks++; if (PAB_RD !== 1'b1) begin failures++; $display("FAIL split_rd_c2 got=%b exp=1", PAB_RD); end
        checks++; if (HLT !== 2'b01) begin failures++; $display("FAIL split_hlt_c2 got=%b exp=01", HLT); end
        MEM_READY = 1'b0;
        tick();
        checks++; if (PAB_RD !== 1'b1) begin failures++; $display("FAIL split_rd_c3 got=%b exp=1", PAB_RD); end
        tick();
        checks++; if (PAB_RD !== 1'b1) begin failures++; $display("FAIL split_rd_c4 got=%b exp=1", PAB_RD); end
        checks++; if (HLT !== 2'b01) begin failures++; $display("FAIL split_hlt_c4 got=%b exp=01", HLT); end
        MEM_VALID = 1'b1;
        MEM_DATA  = 32'h55AA_1234;
        tick();
        checks++; if (HLT !== 2'b00) begin failures++; $display("FAIL split_hlt_c5 got=%b exp=00", HLT); end
        checks++; if (DATAI !== 32'h55AA_1234) begin failures++; $display("FAIL split_datai_c5 got=%h exp=55aa1234", DATAI); end
        checks++; if (PAB_RD !== 1'b0) begin failures++; $display("FAIL split_rd_c5 got=%b exp=0", PAB_RD); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid;
        // Rotation pointer sits at core 1 here, so core 1 wins first.
        RD = 2'b11;
        tick();
        checks++; if (GNT !== 2'b10) begin failures++; $display("FAIL rstmid_gnt_pre got=%b exp=10", GNT); end
        MEM_READY = 1'b1;
        tick();
        MEM_READY = 1'b0;
        checks++; if (PAB_RD !== 1'b1) begin failures++; $display("FAIL rstmid_wait_rd got=%b exp=1", PAB_RD); end
        RESN = 1'b0;
        #1;
        checks++; if ({PAB_VALID, PAB_RD, PAB_WR} !== 3'b000) begin failures++; $display("FAIL rstmid_req got=%b exp=000", {PAB_VALID, PAB_RD, PAB_WR}); end
        checks++; if (PAB_ADDR !== 32'h0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", PAB_ADDR); end
        checks++; if (GNT !== 2'b00) begin failures++; $display("FAIL rstmid_gnt got=%b exp=00", GNT); end
        checks++; if (DATAI !== 32'h0) begin failures++; $display("FAIL rstmid_datai got=%h exp=0", DATAI); end
        checks++; if (HLT !== 2'b11) begin failures++; $display("FAIL rstmid_hlt got=%b exp=11", HLT); end
        tick();
        RESN = 1'b1;
        tick();
        checks++; if (GNT !== 2'b01) begin failures++; $display("FAIL rstmid_gnt_post got=%b exp=01", GNT); end
        checks++; if (PAB_ADDR !== 32'h0000_0300) begin failures++; $display("FAIL rstmid_addr_post got=%h exp=00000300", PAB_ADDR); end
        MEM_READY = 1'b1;
        MEM_VALID = 1'b1;
        MEM_DATA  = 32'h0000_0077;
        tick();
        checks++; if (HLT !== 2'b10) begin failures++; $display("FAIL rstmid_hlt_post got=%b exp=10", HLT); end
        idle_inputs();
        tick();
    endtask

`ifdef PAB_TIMEOUT_EN
    task automatic test_timeout;
        DADDR[63:32] = 32'h0000_0400;
        RD           = 2'b10;
        tick();
        for (int k = 0; k < 7; k++) begin
            tick();
        end
        checks++; if (HLT !== 2'b10) begin failures++; $display("FAIL tmo_hlt_c8 got=%b exp=10", HLT); end
        checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL tmo_err_c8 got=%b exp=0", ERR); end
        checks++; if (PAB_RD !== 1'b1) begin failures++; $display("FAIL tmo_rd_c8 got=%b exp=1", PAB_RD); end
        tick();
        checks++; if (HLT !== 2'b00) begin failures++; $display("FAIL tmo_hlt_c9 got=%b exp=00", HLT); end
        checks++; if (DATAI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL tmo_datai got=%h exp=ffffffff", DATAI); end
        checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL tmo_err_c9 got=%b exp=1", ERR); end
        idle_inputs();
        tick();
        tick();
        checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL tmo_err_sticky got=%b exp=1", ERR); end
        checks++; if (GNT !== 2'b00) begin failures++; $display("FAIL tmo_gnt_idle got=%b exp=00", GNT); end
    endtask
`else
    task automatic test_err_tied;
        tick();
        checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL err_tied got=%b exp=0", ERR); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_write();
        test_contention();
        test_split();
        test_reset_mid();
`ifdef PAB_TIMEOUT_EN
        test_timeout();
`else
        test_err_tied();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
